// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with prefetch FIFO; optional response bypass via IFU_BYPASS_EN
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rom_ce_o,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic [INST_W-1:0]       rom_data_i,
    input  logic                    redirect_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    input  logic                    id_ready_i,
    output logic                    id_valid_o,
    output logic [ADDR_W-1:0]       id_pc_o,
    output logic [INST_W-1:0]       id_inst_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(INST_W / 8);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic              kill;
    logic              issue;
    logic              resp_valid;
    logic              fifo_empty;
    logic              bypass_take;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit;

    // A redirect discards the response arriving in the same cycle
    assign kill       = redirect_i;
    // Registered occupancy plus the outstanding request; a pop this cycle earns no credit
    assign credit     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue      = rst & ~redirect_i & (credit < DEPTH_C);
    assign resp_valid = inflight_q & ~kill;
    assign fifo_empty = (count_q == '0);

`ifdef IFU_BYPASS_EN
    assign bypass_take = fifo_empty & resp_valid;
`else
    assign bypass_take = 1'b0;
`endif

    assign rom_ce_o   = issue;
    assign rom_addr_o = fetch_pc_q;
    assign count_o    = count_q;

    // Present the FIFO head (or a bypassed response) to decode; zeros when nothing is available
    always_comb begin
        id_valid_o = 1'b0;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (!fifo_empty) begin
            id_valid_o = ~redirect_i;
            id_pc_o    = pc_mem[rd_ptr_q];
            id_inst_o  = inst_mem[rd_ptr_q];
        end else if (bypass_take) begin
            id_valid_o = 1'b1;
            id_pc_o    = inflight_pc_q;
            id_inst_o  = rom_data_i;
        end
    end

    // A bypassed response taken by decode is never written; pops only come from the FIFO
    assign pop  = ~fifo_empty & id_valid_o & id_ready_i;
    assign push = resp_valid & ~(bypass_take & id_ready_i);

    // Next-state for fetch PC, in-flight tracking and FIFO pointers/occupancy
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_INC;
            inflight_pc_d = fetch_pc_q;
        end
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            inst_mem[wr_ptr_q] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed scoreboard bench for ifu_prefetch
module tb_ifu_prefetch;

    localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = 32'hDEAD_BEEF;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  count_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_issue = 0;
    logic [31:0] sb[$];
    logic [31:0] popped[$];
    bit          infl = 1'b0;
    logic [31:0] exp_fetch = 32'h0;

    ifu_prefetch #(
        .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .id_ready_i(id_ready_i), .id_valid_o(id_valid_o),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // ROM with one-cycle read latency
    always @(posedge clk) rom_data_i <= rom_ce_o ? (rom_addr_o ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (i < popped.size()) return popped[i];
        return 32'hFFFF_FFFF;
    endfunction

    // One monitored cycle: compare outputs at the falling edge, advance the model, return after the rising edge
    task automatic step();
        int          exp_cnt;
        bit          exp_ce;
        bit          exp_v;
        logic [31:0] pc;
        @(negedge clk);
        if (!rst) begin
            sb.delete();
            infl      = 1'b0;
            exp_fetch = 32'h0;
        end
        exp_cnt = sb.size() - int'(infl);
        check("count", 64'(count_o), 64'(exp_cnt));
        exp_ce = rst && !redirect_i && (sb.size() < DEPTH);
        check("rom_ce", 64'(rom_ce_o), 64'(exp_ce));
        if (exp_ce) check("rom_addr", 64'(rom_addr_o), 64'(exp_fetch));
        n_issue += int'(rom_ce_o);
        exp_v = rst && !redirect_i && (exp_cnt != 0 || (BYP && infl));
        check("id_valid", 64'(id_valid_o), 64'(exp_v));
        if (exp_v && id_ready_i && sb.size() > 0) begin
            pc = sb.pop_front();
            check("id_pc", 64'(id_pc_o), 64'(pc));
            check("id_inst", 64'(id_inst_o), 64'(pc ^ 32'hA5A5_0000));
            popped.push_back(id_pc_o);
        end
        if (!rst) begin
            infl = 1'b0;
        end else if (redirect_i) begin
            sb.delete();
            infl      = 1'b0;
            exp_fetch = redirect_pc_i;
        end else begin
            infl = exp_ce;
            if (exp_ce) begin
                sb.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
        popped.delete();
        n_issue = 0;
    endtask

    initial begin
        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ce", 64'(rom_ce_o), 64'(0));
        check("rst_addr", 64'(rom_addr_o), 64'(0));
        check("rst_valid", 64'(id_valid_o), 64'(0));
        check("rst_pc", 64'(id_pc_o), 64'(0));
        check("rst_inst", 64'(id_inst_o), 64'(0));
        check("rst_count", 64'(count_o), 64'(0));

        // straight-line fetch
        id_ready_i = 1'b1;
        rst = 1'b1;
        popped.delete();
        repeat (12) step();
        check("t1_pops", 64'(popped.size()), BYP ? 64'(11) : 64'(10));
        check("t1_first", 64'(pop_at(0)), 64'(32'h0));
        check("t1_sixth", 64'(pop_at(5)), 64'(32'h14));

        // backpressure
        id_ready_i = 1'b0;
        reset_pulse();
        repeat (8) step();
        check("t2_issues", 64'(n_issue), 64'(4));
        check("t2_count", 64'(count_o), 64'(4));
        check("t2_ce", 64'(rom_ce_o), 64'(0));
        id_ready_i = 1'b1;
        repeat (6) step();
        check("t2_p0", 64'(pop_at(0)), 64'(32'h0));
        check("t2_p1", 64'(pop_at(1)), 64'(32'h4));
        check("t2_p2", 64'(pop_at(2)), 64'(32'h8));
        check("t2_p3", 64'(pop_at(3)), 64'(32'hC));
        check("t2_p4", 64'(pop_at(4)), 64'(32'h10));

        // redirect with buffered entries and a request in flight
        id_ready_i = 1'b0;
        reset_pulse();
        repeat (3) step();
        check("t3_count_pre", 64'(count_o), 64'(2));
        redirect_i = 1'b1; redirect_pc_i = 32'h100; id_ready_i = 1'b1;
        step();
        redirect_i = 1'b0;
        check("t3_count_post", 64'(count_o), 64'(0));
        popped.delete();
        repeat (6) step();
        check("t3_first", 64'(pop_at(0)), 64'(32'h100));
        check("t3_second", 64'(pop_at(1)), 64'(32'h104));

        // redirect while decode is ready and head is valid
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        popped.delete();
        step();
        redirect_i = 1'b0;
        check("t4_no_pop", 64'(popped.size()), 64'(0));
        repeat (5) step();
        check("t4_first", 64'(pop_at(0)), 64'(32'h200));

        // asynchronous reset mid-operation
        id_ready_i = 1'b0;
        reset_pulse();
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        check("t5_ce", 64'(rom_ce_o), 64'(0));
        check("t5_addr", 64'(rom_addr_o), 64'(0));
        check("t5_valid", 64'(id_valid_o), 64'(0));
        check("t5_pc", 64'(id_pc_o), 64'(0));
        check("t5_inst", 64'(id_inst_o), 64'(0));
        check("t5_count", 64'(count_o), 64'(0));
        step();
        rst = 1'b1;
        id_ready_i = 1'b1;
        popped.delete();
        repeat (6) step();
        check("t5_first", 64'(pop_at(0)), 64'(32'h0));

        // PC wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        popped.delete();
        repeat (6) step();
        check("t6_p0", 64'(pop_at(0)), 64'(32'hFFFF_FFFC));
        check("t6_p1", 64'(pop_at(1)), 64'(32'h0));
        check("t6_p2", 64'(pop_at(2)), 64'(32'h4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
